chunked_serial_adder: RTL

//  - Parametrised multi-cycle adder; generalises the fixed 4-bit ripple adder to WIDTH bits.
//  - Adds CHUNK bits per clock, carry held in a register between chunks: small area for wide operands.
//  - Valid/ready handshake on both input and output. Sits between an operand source and a result consumer.

---
 rtl/chunked_serial_adder_pkg.sv | 15 +
 rtl/chunked_serial_adder_chunk_adder.sv | 25 ++
 rtl/chunked_serial_adder.sv | 114 +++++++++++
 3 files changed

// File: rtl/chunked_serial_adder_pkg.sv
// rtl/chunked_serial_adder_pkg.sv - state encodings and index-width helper for chunked_serial_adder
package chunked_serial_adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Chunk index needs at least one bit even when there is a single chunk.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/chunked_serial_adder_chunk_adder.sv
// rtl/chunked_serial_adder_chunk_adder.sv - combinational CHUNK-bit ripple adder (module chunk_adder)
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             ci,
   output logic [CHUNK-1:0] s,
   output logic             co
);

   logic [CHUNK:0] c;

   always_comb begin
      s    = '0;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < CHUNK; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      co = c[CHUNK];
   end

endmodule

// File: rtl/chunked_serial_adder.sv
// rtl/chunked_serial_adder.sv - multi-cycle WIDTH-bit adder, CHUNK bits per clock; ovf port with ADDER_OVF_EN
module chunked_serial_adder
   import chunked_serial_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW     = idx_width(NCHUNK);
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   state_t           state, state_nxt;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] a_q, b_q, sum_q;
   logic             carry, cout_q;
   logic [CHUNK-1:0] ca, cb, cs;
   logic             cco;

   assign ca = a_q[idx*CHUNK +: CHUNK];
   assign cb = b_q[idx*CHUNK +: CHUNK];

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a  (ca),
      .b  (cb),
      .ci (carry),
      .s  (cs),
      .co (cco)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (idx == LAST) state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         carry  <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else if (state == S_IDLE && in_valid) begin
         a_q   <= a;
         b_q   <= b;
         carry <= cin;
         idx   <= '0;
      end else if (state == S_RUN) begin
         sum_q[idx*CHUNK +: CHUNK] <= cs;
         carry <= cco;
         if (idx == LAST) begin
            cout_q <= cco;
            idx    <= '0;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

`ifdef ADDER_OVF_EN
   logic ovf_q;

   // Final chunk carries the sign bit of the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_q <= 1'b0;
      else if (state == S_RUN && idx == LAST)
         ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (cs[CHUNK-1] != a_q[WIDTH-1]);
   end

   assign ovf = ovf_q;
`endif

endmodule
